mem_copy_master: RTL and testbench

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

---
 rtl/mem_copy_master.sv | 119 +++++++++++
 tb/tb_mem_copy_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// Single-outstanding bus master that copies cmd_len_i words from a source to a
// destination address, one read followed by one write per word.
module mem_copy_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_src_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_dst_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    req_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    we_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] be_o,
    input  logic                    gnt_i,
    input  logic                    rvalid_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BE_W);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [LEN_WIDTH-1:0]  cnt_inc;

    assign cnt_inc = cnt_q + LEN_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    src_d   = cmd_src_i;
                    dst_d   = cmd_dst_i;
                    len_d   = cmd_len_i;
                    cnt_d   = '0;
                    state_d = (cmd_len_i == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (gnt_i) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rvalid_i) begin
                    buf_d   = rdata_i;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (gnt_i) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                // Addresses wrap naturally at the register width.
                if (rvalid_i) begin
                    cnt_d   = cnt_inc;
                    src_d   = src_q + STEP;
                    dst_d   = dst_q + STEP;
                    state_d = (cnt_inc == len_q) ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Moore outputs: bus fields are zero whenever no request is driven.
    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign req_o       = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign we_o        = (state_q == S_WR_REQ);
    assign addr_o      = (state_q == S_RD_REQ) ? src_q :
                         (state_q == S_WR_REQ) ? dst_q : '0;
    assign wdata_o     = (state_q == S_WR_REQ) ? buf_q : '0;
    assign be_o        = (state_q == S_WR_REQ) ? {BE_W{1'b1}} : '0;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: a word memory responder on the bus side and a
// word-by-word copy model that predicts every bus request and the final memory.
module tb_mem_copy_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_src_i, cmd_dst_i, cmd_len_i;
    logic        busy_o, done_o, req_o, we_o;
    logic [7:0]  addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        gnt_i, rvalid_i;
    logic [31:0] rdata_i;

    mem_copy_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i), .cmd_len_i(cmd_len_i),
        .busy_o(busy_o), .done_o(done_o),
        .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .wdata_o(wdata_o), .be_o(be_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] bus_mem [64];
    logic [31:0] ref_mem [64];
    logic [40:0] exp_q [$];

    int          stall_cnt, stall_max, dly_max, spur;
    bit          pend;
    int          pend_dly;
    logic        pend_we;
    logic [7:0]  pend_addr;
    bit          hold_v;
    logic [7:0]  hold_addr;
    logic        hold_we;
    logic [31:0] hold_wdata;

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        int         first_stall;
        int         spur;
        int         exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected bus traffic of a copy: read word i, then write it to dst word i.
    task automatic build_exp(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len);
        logic [7:0]  ra, wa;
        logic [31:0] d;
        for (int i = 0; i < int'(len); i++) begin
            ra = src + 8'(4 * i);
            wa = dst + 8'(4 * i);
            d  = ref_mem[ra[7:2]];
            exp_q.push_back({1'b0, ra, 32'h0});
            exp_q.push_back({1'b1, wa, d});
            ref_mem[wa[7:2]] = d;
        end
    endtask

    // One bus-side cycle, called at the falling edge.
    task automatic bus_step();
        logic [40:0] e;
        check("req_while_pending", {63'd0, req_o & pend}, 64'd0);
        if (!req_o) check("idle_bus_zero", {23'd0, we_o, addr_o, wdata_o}, 64'd0);
        if (hold_v) begin
            check("req_held", {63'd0, req_o}, 64'd1);
            check("held_fields", {23'd0, we_o, addr_o, wdata_o}, {23'd0, hold_we, hold_addr, hold_wdata});
        end
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
        if (pend) begin
            if (pend_dly == 0) begin
                rvalid_i = 1'b1;
                if (!pend_we) rdata_i = bus_mem[pend_addr[7:2]];
                pend = 1'b0;
            end else begin
                pend_dly--;
            end
        end else if (req_o && (spur == 2 || (spur == 1 && $urandom_range(0, 2) == 0))) begin
            rvalid_i = 1'b1;
            rdata_i  = $urandom;
        end
        gnt_i = 1'b0;
        hold_v = 1'b0;
        if (req_o) begin
            if (stall_cnt > 0) begin
                stall_cnt--;
                hold_v = 1'b1; hold_addr = addr_o; hold_we = we_o; hold_wdata = wdata_o;
            end else begin
                gnt_i = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", {23'd0, we_o, addr_o, wdata_o}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_req", {23'd0, we_o, addr_o, wdata_o}, {23'd0, e});
                end
                if (we_o) begin
                    check("be_write", {60'd0, be_o}, 64'hF);
                    bus_mem[addr_o[7:2]] = wdata_o;
                end
                pend = 1'b1; pend_we = we_o; pend_addr = addr_o;
                pend_dly  = $urandom_range(0, dly_max);
                stall_cnt = $urandom_range(0, stall_max);
            end
        end else if (spur != 0) begin
            gnt_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic issue_cmd(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len);
        check("cmd_ready_idle", {63'd0, cmd_ready_o}, 64'd1);
        cmd_src_i = src; cmd_dst_i = dst; cmd_len_i = len; cmd_valid_i = 1'b1;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        cmd_src_i = $urandom; cmd_dst_i = $urandom; cmd_len_i = $urandom;
    endtask

    task automatic run_cmd(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                           input int first_stall, output int lat);
        build_exp(src, dst, len);
        stall_cnt = first_stall; pend = 1'b0; hold_v = 1'b0;
        issue_cmd(src, dst, len);
        lat = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            check("busy_active", {63'd0, busy_o}, 64'd1);
            if (done_o) begin
                lat = cyc;
                break;
            end
            bus_step();
            @(negedge clk);
        end
        gnt_i = 1'b0; rvalid_i = 1'b0;
        check("done_seen", {63'd0, lat != -1}, 64'd1);
        check("all_reqs_seen", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        check("done_one_cycle", {62'd0, done_o, busy_o}, 64'd0);
        check("ready_after", {63'd0, cmd_ready_o}, 64'd1);
    endtask

    vec_t vecs [5];
    int   lat;
    int   bad_words;

    initial begin
        rst = 1'b1; cmd_valid_i = 1'b0; cmd_src_i = '0; cmd_dst_i = '0; cmd_len_i = '0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
        stall_max = 0; dly_max = 0; spur = 0;
        for (int i = 0; i < 64; i++) bus_mem[i] = $urandom;
        bus_mem[0] = 32'hDEADBEEF;
        for (int i = 0; i < 64; i++) ref_mem[i] = bus_mem[i];

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {19'd0, req_o, we_o, addr_o, wdata_o, be_o, busy_o, done_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {63'd0, cmd_ready_o}, 64'd1);
        check("rst_idle_bus", {19'd0, req_o, we_o, addr_o, wdata_o, be_o, busy_o, done_o}, 64'd0);

        // Directed vectors: zero-wait bus unless a first-request stall is given.
        vecs[0] = '{src: 8'h00, dst: 8'h40, len: 8'd1, first_stall: 0, spur: 0, exp_lat: 5};
        vecs[1] = '{src: 8'h10, dst: 8'h80, len: 8'd4, first_stall: 0, spur: 0, exp_lat: 17};
        vecs[2] = '{src: 8'h20, dst: 8'h30, len: 8'd0, first_stall: 0, spur: 0, exp_lat: 1};
        vecs[3] = '{src: 8'hFC, dst: 8'hA0, len: 8'd2, first_stall: 0, spur: 0, exp_lat: 9};
        vecs[4] = '{src: 8'h50, dst: 8'hC0, len: 8'd3, first_stall: 3, spur: 2, exp_lat: 16};
        for (int v = 0; v < 5; v++) begin
            spur = vecs[v].spur;
            run_cmd(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].first_stall, lat);
            check($sformatf("latency_v%0d", v), 64'(lat), 64'(vecs[v].exp_lat));
            if (v == 0) check("copied_deadbeef", {32'd0, bus_mem[16]}, {32'd0, 32'hDEADBEEF});
        end
        spur = 0;

        // Reset while the write response is outstanding.
        build_exp(8'h00, 8'h40, 8'd2);
        stall_cnt = 0; pend = 1'b0; hold_v = 1'b0;
        issue_cmd(8'h00, 8'h40, 8'd2);
        for (int k = 0; k < 3; k++) begin
            bus_step();
            @(negedge clk);
        end
        gnt_i = 1'b0; rvalid_i = 1'b0;
        check("pre_rst_busy", {62'd0, busy_o, req_o}, 64'd2);
        rst = 1'b1;
        #1;
        check("rst_abort", {61'd0, req_o, busy_o, done_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_done_after_abort", {62'd0, done_o, busy_o}, 64'd0);
        end
        exp_q.delete(); pend = 1'b0; hold_v = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = bus_mem[i];
        run_cmd(8'h08, 8'h60, 8'd1, 0, lat);
        check("latency_after_rst", 64'(lat), 64'd5);

        // Randomized commands with random stalls, response delays and spurious strobes.
        stall_max = 2; dly_max = 2; spur = 1;
        for (int t = 0; t < 25; t++) begin
            logic [7:0] s, d, l;
            s = {2'($urandom), 6'd0} | 8'($urandom_range(0, 63) << 2);
            d = 8'($urandom_range(0, 63) << 2);
            l = 8'($urandom_range(0, 6));
            run_cmd(s, d, l, $urandom_range(0, 2), lat);
            n_tests++;
            if (lat < 4 * int'(l) + 1) begin
                n_fail++;
                $display("FAIL rand_latency: got %0d expected at least %0d", lat, 4 * int'(l) + 1);
            end
        end

        bad_words = 0;
        for (int i = 0; i < 64; i++) if (bus_mem[i] !== ref_mem[i]) bad_words++;
        check("final_memory_bad_words", 64'(bad_words), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
